// File: rtl/stack_ctrl.sv
// stack_ctrl: sequences push, pop and set operations on the CPU stack.
// It drives the external SP register via sp_drive/sp_set, reads SP back on
// sp_in, and performs the stack memory access with a req/ack handshake.
// The SP convention is empty-ascending: sp_in is the number of words on the stack.
//
// Optional build macro: STACK_CTRL_TIMEOUT_EN
//   defined   -> a watchdog aborts a memory access after TIMEOUT cycles
//                without mem_ack and reports err_code 11.
//   undefined -> the controller waits for mem_ack indefinitely; TIMEOUT is
//                only range-checked.
module stack_ctrl #(
  parameter int unsigned DEPTH      = 1024,
  parameter logic [31:0] STACK_BASE = 32'h0000_F000,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_req,
  input  logic        pop_req,
  input  logic        set_req,
  input  logic [31:0] push_data,
  input  logic [31:0] set_value,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] pop_data,
  input  logic [31:0] sp_in,
  output logic [1:0]  sp_drive,
  output logic [31:0] sp_set,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PUSH_WAIT = 2'd1,
    POP_WAIT  = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  localparam logic [1:0] DRV_HOLD = 2'b00;
  localparam logic [1:0] DRV_INC  = 2'b01;
  localparam logic [1:0] DRV_DEC  = 2'b10;
  localparam logic [1:0] DRV_LOAD = 2'b11;

  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_UNF = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  // A zero watchdog limit would abort every access before it could complete.
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("stack_ctrl: TIMEOUT must be at least 1");
  end

  state_t state;

  // Word address of a stack slot; wraps modulo 2^32 like the bus address.
  function automatic logic [31:0] slot_addr(input logic [31:0] slot);
    return STACK_BASE + slot;
  endfunction

  // Request acceptance checks evaluated against the current SP.
  logic set_bad;
  logic push_full;
  logic pop_empty;

  // Bounds checks for the three request kinds.
  always_comb begin
    set_bad   = (set_value > DEPTH_W);
    push_full = (sp_in >= DEPTH_W);
    pop_empty = (sp_in == 32'd0);
  end

  // Idle is the only accepting state; reset forces ready low immediately.
  assign ready = (state == IDLE) && !rst;

`ifdef STACK_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             tmo_hit;

  // The access has waited its full budget when this cycle is the last one.
  assign tmo_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
`endif

  // Main controller FSM with registered handshake, SP and memory outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      pop_data  <= 32'd0;
      sp_drive  <= DRV_HOLD;
      sp_set    <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
`ifdef STACK_CTRL_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          // set outranks push, push outranks pop; the losers are dropped.
          if (set_req) begin
            if (set_bad) begin
              err      <= 1'b1;
              err_code <= ERR_OVF;
            end else begin
              sp_set   <= set_value;
              sp_drive <= DRV_LOAD;
              done     <= 1'b1;
              state    <= UPDATE;
            end
          end else if (push_req) begin
            if (push_full) begin
              err      <= 1'b1;
              err_code <= ERR_OVF;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= slot_addr(sp_in);
              mem_wdata <= push_data;
`ifdef STACK_CTRL_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
              state     <= PUSH_WAIT;
            end
          end else if (pop_req) begin
            if (pop_empty) begin
              err      <= 1'b1;
              err_code <= ERR_UNF;
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= slot_addr(sp_in - 32'd1);
`ifdef STACK_CTRL_TIMEOUT_EN
              wait_cnt <= '0;
`endif
              state    <= POP_WAIT;
            end
          end
        end

        PUSH_WAIT, POP_WAIT: begin
          // Request fields stay put until the memory acknowledges.
          if (mem_ack) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            if (state == PUSH_WAIT) begin
              sp_drive <= DRV_INC;
            end else begin
              sp_drive <= DRV_DEC;
              pop_data <= mem_rdata;
            end
            state <= UPDATE;
          end
`ifdef STACK_CTRL_TIMEOUT_EN
          else if (tmo_hit) begin
            mem_req  <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_TMO;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end

        UPDATE: begin
          // SP changes at the end of this cycle, so it is current when ready returns.
          sp_drive <= DRV_HOLD;
          state    <= IDLE;
        end

        default: begin
          sp_drive <= DRV_HOLD;
          mem_req  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed, table-driven bench for stack_ctrl with a model
// SP register and a hand-driven memory acknowledge.
module tb_stack_ctrl;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_req, pop_req, set_req;
  logic [31:0] push_data, set_value;
  logic        ready, done, err;
  logic [1:0]  err_code;
  logic [31:0] pop_data;
  logic [31:0] sp_in;
  logic [1:0]  sp_drive;
  logic [31:0] sp_set;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  stack_ctrl #(
    .DEPTH     (DEPTH),
    .STACK_BASE(32'h0000_F000),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .push_req (push_req),
    .pop_req  (pop_req),
    .set_req  (set_req),
    .push_data(push_data),
    .set_value(set_value),
    .ready    (ready),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .pop_data (pop_data),
    .sp_in    (sp_in),
    .sp_drive (sp_drive),
    .sp_set   (sp_set),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // External SP register driven by the controller.
  logic [31:0] sp;
  always_ff @(posedge clk) begin
    if (rst) sp <= 32'd0;
    else begin
      case (sp_drive)
        2'b01:   sp <= sp + 32'd1;
        2'b10:   sp <= sp - 32'd1;
        2'b11:   sp <= sp_set;
        default: sp <= sp;
      endcase
    end
  end
  assign sp_in = sp;

  typedef struct {
    logic [2:0]  req;      // {set, push, pop}
    logic [31:0] val;      // push_data and set_value
    int          dly;      // cycles of mem_req before mem_ack
    logic [31:0] rdata;
    logic        exp_err;
    logic [1:0]  exp_code;
    logic        exp_mem;
    logic [31:0] exp_addr;
    logic [31:0] exp_sp;   // SP once ready returns
    logic [1:0]  exp_drv;  // sp_drive during done
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic wait_ready(input int idx);
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
    check("ready_wait", idx, {31'd0, ready}, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          cyc, waitc, done_cyc;
    logic        seen_done, seen_err, seen_mem, drv_bad, req_bad, we;
    logic [1:0]  code, drv;
    logic [31:0] addr, wdata, set_cap;
    seen_done = 0; seen_err = 0; seen_mem = 0; drv_bad = 0; req_bad = 0;
    we = 0; code = 0; drv = 0; addr = 0; wdata = 0; set_cap = 0;
    cyc = 0; waitc = 0; done_cyc = 0;
    wait_ready(idx);
    set_req   = v.req[2];
    push_req  = v.req[1];
    pop_req   = v.req[0];
    push_data = v.val;
    set_value = v.val;
    while (!(seen_done || seen_err) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      set_req = 0; push_req = 0; pop_req = 0; mem_ack = 0;
      if (err) begin seen_err = 1; code = err_code; end
      if (done) begin
        seen_done = 1; done_cyc = cyc; drv = sp_drive; set_cap = sp_set;
      end else if (sp_drive !== 2'b00) drv_bad = 1;
      if (mem_req) begin
        if (!seen_mem) begin
          seen_mem = 1; addr = mem_addr; we = mem_we; wdata = mem_wdata;
        end else if (mem_addr !== addr || mem_we !== we || mem_wdata !== wdata) req_bad = 1;
        if (waitc == v.dly) begin mem_ack = 1; mem_rdata = v.rdata; end
        else waitc++;
      end
    end
    check("err", idx, {31'd0, seen_err}, {31'd0, v.exp_err});
    check("done", idx, {31'd0, seen_done}, {31'd0, !v.exp_err});
    check("mem_access", idx, {31'd0, seen_mem}, {31'd0, v.exp_mem});
    check("drive_outside_update", idx, {31'd0, drv_bad}, 32'd0);
    if (v.exp_err) begin
      check("err_code", idx, {30'd0, code}, {30'd0, v.exp_code});
      check("ready_during_err", idx, {31'd0, ready}, 32'd1);
    end else begin
      check("sp_drive", idx, {30'd0, drv}, {30'd0, v.exp_drv});
      check("ready_in_update", idx, {31'd0, ready}, 32'd0);
    end
    if (v.exp_mem) begin
      check("mem_addr", idx, addr, v.exp_addr);
      check("mem_we", idx, {31'd0, we}, {31'd0, (v.exp_drv == 2'b01)});
      check("mem_stable", idx, {31'd0, req_bad}, 32'd0);
      check("latency", idx, done_cyc, v.dly + 2);
      if (v.exp_drv == 2'b01) check("mem_wdata", idx, wdata, v.val);
      if (v.exp_drv == 2'b10) check("pop_data", idx, pop_data, v.rdata);
    end
    if (!v.exp_err && v.exp_drv == 2'b11) begin
      check("sp_set", idx, set_cap, v.val);
      check("set_latency", idx, done_cyc, 1);
    end
    @(negedge clk);
    check("ready_after", idx, {31'd0, ready}, 32'd1);
    check("pulse_end", idx, {30'd0, done, err}, 32'd0);
    check("sp_drive_idle", idx, {30'd0, sp_drive}, 32'd0);
    check("sp_after", idx, sp_in, v.exp_sp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    //             req     val           dly rdata         err code mem addr          sp          drv
    vecs[0]  = '{3'b010, 32'hDEAD_BEEF, 2, 32'h0,        1'b0, 2'b00, 1'b1, 32'h0000_F000, 32'd1,    2'b01};
    vecs[1]  = '{3'b100, 32'd3,         0, 32'h0,        1'b0, 2'b00, 1'b0, 32'h0,         32'd3,    2'b11};
    vecs[2]  = '{3'b001, 32'h0,         1, 32'h1234_5678,1'b0, 2'b00, 1'b1, 32'h0000_F002, 32'd2,    2'b10};
    vecs[3]  = '{3'b111, 32'd5,         0, 32'h0,        1'b0, 2'b00, 1'b0, 32'h0,         32'd5,    2'b11};
    vecs[4]  = '{3'b011, 32'h0BAD_F00D, 0, 32'h0,        1'b0, 2'b00, 1'b1, 32'h0000_F005, 32'd6,    2'b01};
    vecs[5]  = '{3'b100, 32'd1025,      0, 32'h0,        1'b1, 2'b01, 1'b0, 32'h0,         32'd6,    2'b00};
    vecs[6]  = '{3'b100, 32'd1024,      0, 32'h0,        1'b0, 2'b00, 1'b0, 32'h0,         32'd1024, 2'b11};
    vecs[7]  = '{3'b010, 32'h7777_7777, 0, 32'h0,        1'b1, 2'b01, 1'b0, 32'h0,         32'd1024, 2'b00};
    vecs[8]  = '{3'b100, 32'd1023,      0, 32'h0,        1'b0, 2'b00, 1'b0, 32'h0,         32'd1023, 2'b11};
    vecs[9]  = '{3'b010, 32'h5555_AAAA, 3, 32'h0,        1'b0, 2'b00, 1'b1, 32'h0000_F3FF, 32'd1024, 2'b01};
    vecs[10] = '{3'b001, 32'h0,         0, 32'hCAFE_F00D,1'b0, 2'b00, 1'b1, 32'h0000_F3FF, 32'd1023, 2'b10};
    vecs[11] = '{3'b100, 32'd1,         0, 32'h0,        1'b0, 2'b00, 1'b0, 32'h0,         32'd1,    2'b11};
    vecs[12] = '{3'b001, 32'h0,         2, 32'h0F0F_0F0F,1'b0, 2'b00, 1'b1, 32'h0000_F000, 32'd0,    2'b10};
    vecs[13] = '{3'b001, 32'h0,         0, 32'h0,        1'b1, 2'b10, 1'b0, 32'h0,         32'd0,    2'b00};
    vecs[14] = '{3'b101, 32'hFFFF_FFFF, 0, 32'h0,        1'b1, 2'b01, 1'b0, 32'h0,         32'd0,    2'b00};
    vecs[15] = '{3'b110, 32'd0,         0, 32'h0,        1'b0, 2'b00, 1'b0, 32'h0,         32'd0,    2'b11};

    rst = 1; push_req = 0; pop_req = 0; set_req = 0;
    push_data = 0; set_value = 0; mem_ack = 0; mem_rdata = 0;

    // Reset state
    @(negedge clk);
    check("ready_in_reset", 0, {31'd0, ready}, 32'd0);
    rst = 0;
    @(negedge clk);
    check("rst_ready", 0, {31'd0, ready}, 32'd1);
    check("rst_pulses", 0, {30'd0, done, err}, 32'd0);
    check("rst_err_code", 0, {30'd0, err_code}, 32'd0);
    check("rst_pop_data", 0, pop_data, 32'd0);
    check("rst_sp_drive", 0, {30'd0, sp_drive}, 32'd0);
    check("rst_sp_set", 0, sp_set, 32'd0);
    check("rst_mem_ctl", 0, {30'd0, mem_req, mem_we}, 32'd0);
    check("rst_mem_addr", 0, mem_addr, 32'd0);
    check("rst_mem_wdata", 0, mem_wdata, 32'd0);

    // Directed vector table
    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Reset while a push waits for its acknowledge, then a late ack
    wait_ready(100);
    push_req = 1; push_data = 32'h1111_2222;
    @(negedge clk);
    push_req = 0;
    check("busy_mem_req", 100, {31'd0, mem_req}, 32'd1);
    pop_req = 1;
    @(negedge clk);
    pop_req = 0;
    check("busy_ready", 100, {31'd0, ready}, 32'd0);
    rst = 1;
    @(negedge clk);
    check("midrst_mem_req", 100, {31'd0, mem_req}, 32'd0);
    check("midrst_ready", 100, {31'd0, ready}, 32'd0);
    check("midrst_err_code", 100, {30'd0, err_code}, 32'd0);
    check("midrst_pop_data", 100, pop_data, 32'd0);
    rst = 0; mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_ack = 0;
    check("late_ack_ready", 100, {31'd0, ready}, 32'd1);
    check("late_ack_done", 100, {30'd0, done, err}, 32'd0);
    check("late_ack_drive", 100, {30'd0, sp_drive}, 32'd0);
    check("late_ack_mem_req", 100, {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check("late_ack_sp", 100, sp_in, 32'd0);
    check("late_ack_idle", 100, {31'd0, mem_req, sp_drive}, 32'd0);

`ifdef STACK_CTRL_TIMEOUT_EN
    // Push with no acknowledge: watchdog abort
    begin
      int   req_cyc, cyc;
      logic seen_err;
      logic [1:0] code;
      req_cyc = 0; cyc = 0; seen_err = 0; code = 0;
      wait_ready(200);
      push_req = 1; push_data = 32'h3333_4444;
      while (!seen_err && cyc < 40) begin
        @(negedge clk);
        push_req = 0;
        cyc++;
        if (mem_req) req_cyc++;
        if (err) begin seen_err = 1; code = err_code; end
      end
      check("tmo_err", 200, {31'd0, seen_err}, 32'd1);
      check("tmo_code", 200, {30'd0, code}, 32'd3);
      check("tmo_wait_cycles", 200, req_cyc, TIMEOUT);
      check("tmo_mem_req", 200, {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      check("tmo_sp", 200, sp_in, 32'd0);
      check("tmo_ready", 200, {31'd0, ready}, 32'd1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
